// File: rtl/npc_ras_unit.sv
// ---------------------------------------------------------------------------
// npc_ras_unit
//   Fetch-stage program-counter unit for the pipelined MIPS core. It holds the
//   fetch PC and picks the next PC from these sources, highest priority first:
//   exception, eret, jr, jal, taken branch, sequential. It also tracks whether
//   the fetched instruction sits in a branch delay slot.
//
//   With NPC_RAS_EN defined, a circular return-address stack is added. It
//   records jal return addresses and scores jr $31 predictions against the
//   resolved register target. The RAS only predicts and collects statistics;
//   redirects always use the real jr operand. With NPC_RAS_EN undefined, no
//   RAS storage is built and the RAS outputs are tied to zero.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   stall      hold F/D (ignored when req is high)
//   req        exception/interrupt request
//   eret_D     eret in D, redirect to epc
//   epc        EPC value from CP0
//   jr_D       jr in D, redirect to a1_D
//   ret_D      the jr in D reads $31 (RAS pop candidate)
//   jal_D      jal in D
//   br_taken_D resolved taken branch in D
//   imm_D      branch offset (words)
//   index_D    jal index
//   a1_D       forwarded rs value (jr target)
//   pc_F       current fetch PC (registered)
//   npc_F      next PC (combinational)
//   bd_F       fetched instruction is a delay slot (registered)
//   ras_top    RAS top entry, 0 when empty
//   ras_valid  RAS non-empty
//   ras_miss   saturating count of return mispredicts
// ---------------------------------------------------------------------------
module npc_ras_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4,
    parameter int          MISS_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req,
    input  logic              eret_D,
    input  logic [ADDR_W-1:0] epc,
    input  logic              jr_D,
    input  logic              ret_D,
    input  logic              jal_D,
    input  logic              br_taken_D,
    input  logic [15:0]       imm_D,
    input  logic [25:0]       index_D,
    input  logic [ADDR_W-1:0] a1_D,
    output logic [ADDR_W-1:0] pc_F,
    output logic [ADDR_W-1:0] npc_F,
    output logic              bd_F,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_valid,
    output logic [MISS_W-1:0] ras_miss
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] EXC_VEC_W  = ADDR_W'(EXC_VEC);

    logic [ADDR_W-1:0] r_pc_F;
    logic              r_bd_F;
    logic              w_adv;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_npc;

    // A pending exception must be taken even while the pipeline is stalled.
    assign w_adv      = ~stall | req;
    assign w_pc_plus4 = r_pc_F + ADDR_W'(4);
    assign w_br_off   = {{(ADDR_W-18){imm_D[15]}}, imm_D, 2'b00};

    always_comb begin
        w_npc = w_pc_plus4;
        if (req)
            w_npc = EXC_VEC_W;
        else if (eret_D)
            w_npc = epc;
        else if (jr_D)
            w_npc = a1_D;
        else if (jal_D)
            w_npc = {r_pc_F[ADDR_W-1:28], index_D, 2'b00};
        else if (br_taken_D)
            w_npc = r_pc_F + w_br_off;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc_F <= RESET_PC_W;
            r_bd_F <= 1'b0;
        end else if (w_adv) begin
            r_pc_F <= w_npc;
            // Exception and eret targets are never delay slots.
            r_bd_F <= (jr_D | jal_D | br_taken_D) & ~req & ~eret_D;
        end
    end

    assign pc_F  = r_pc_F;
    assign npc_F = w_npc;
    assign bd_F  = r_bd_F;

`ifdef NPC_RAS_EN
    localparam int             PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W:0]    r_cnt;
    logic [MISS_W-1:0] r_miss;
    logic [PTR_W-1:0]  w_top_idx;
    logic [ADDR_W-1:0] w_top;
    logic              w_push;
    logic              w_pop;
    logic              w_miss;

    // jr outranks jal, so a cycle can never both push and pop.
    assign w_push    = w_adv & jal_D & ~jr_D & ~req & ~eret_D;
    assign w_pop     = w_adv & jr_D & ret_D & ~req & ~eret_D;
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_top     = (r_cnt != '0) ? r_ras[w_top_idx] : '0;
    // Popping an empty stack counts as a mispredict.
    assign w_miss    = w_pop & ((r_cnt == '0) | (w_top != a1_D));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++)
                r_ras[i] <= '0;
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_miss <= '0;
        end else begin
            if (w_push) begin
                // When full, this overwrites the oldest entry.
                r_ras[r_ptr] <= w_pc_plus4;
                r_ptr        <= r_ptr + PTR_W'(1);
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + (PTR_W+1)'(1);
            end else if (w_pop && r_cnt != '0) begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - (PTR_W+1)'(1);
            end
            if (w_miss && r_miss != '1)
                r_miss <= r_miss + MISS_W'(1);
        end
    end

    assign ras_top   = w_top;
    assign ras_valid = (r_cnt != '0);
    assign ras_miss  = r_miss;
`else
    logic w_unused_ret;
    assign w_unused_ret = ret_D;

    assign ras_top   = '0;
    assign ras_valid = 1'b0;
    assign ras_miss  = '0;
`endif

endmodule
